// File: rtl/sram_bus_pkg.sv
// Shared types and defaults for the static-memory bus initiator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sram_bus_pkg;

  localparam int DEF_ADDR_W     = 13;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_SETUP_CYC  = 1;
  localparam int DEF_STROBE_CYC = 2;
  localparam int DEF_HOLD_CYC   = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_TURN   = 3'd1,
    ST_SETUP  = 3'd2,
    ST_STROBE = 3'd3,
    ST_HOLD   = 3'd4
  } state_t;

  // Largest of the three phase lengths; sizes the shared phase counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return m;
  endfunction

endpackage

// File: rtl/sram_data_io.sv
// Tri-state pad wrapper for the bidirectional memory data bus.
// Latency: combinational in both directions.
// Backpressure: none; pad floats whenever oe is low.
module sram_data_io #(
  parameter int DATA_W = 8
) (
  inout  wire  [DATA_W-1:0] pad,
  input  logic [DATA_W-1:0] dout,
  input  logic              oe,
  output logic [DATA_W-1:0] din
);

  assign pad = oe ? dout : {DATA_W{1'bz}};
  assign din = pad;

endmodule

// File: rtl/sram_bus_master.sv
// Turns single-cycle requests into timed ncs/nwe/nrd cycles on an async SRAM bus.
// Latency: accept->done = SETUP+STROBE+HOLD+1 edges, +1 when a read->write turnaround is needed.
// Backpressure: busy high while a cycle runs; req is ignored until busy drops.
module sram_bus_master
  import sram_bus_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int STROBE_CYC = DEF_STROBE_CYC,
  parameter int HOLD_CYC   = DEF_HOLD_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] addr,
  inout  wire  [DATA_W-1:0] sram_data,
  output logic              ncs,
  output logic              nwe,
  output logic              nrd
);

  // One counter serves every phase, so it only has to hold the longest one.
  localparam int CNT_W = $clog2(max3(SETUP_CYC, STROBE_CYC, HOLD_CYC) + 1);

  // The counter is loaded with length-1 and a phase ends when it reads zero.
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;

  logic              wr_q;
  logic              last_rd;
  logic [DATA_W-1:0] wdata_q;
  logic              oe_q;
  logic [DATA_W-1:0] din;

  logic              accept;
  logic              phase_end;
  logic              op_wr;
  logic              in_cycle_nxt;
  logic              ncs_nxt;
  logic              nwe_nxt;
  logic              nrd_nxt;
  logic              oe_nxt;
  logic              done_nxt;
  logic              capture;

  sram_data_io #(
    .DATA_W (DATA_W)
  ) u_data_io (
    .pad  (sram_data),
    .dout (wdata_q),
    .oe   (oe_q),
    .din  (din)
  );

  assign busy = (state != ST_IDLE);

  // State and phase-counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state, counter reload, and the next value of every registered bus pin.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    phase_end = (cnt == '0);

    case (state)
      ST_IDLE: begin
        if (req) begin
          accept = 1'b1;
          // A write straight after a read gets one dead cycle so the memory
          // has released the data lines before we start driving them.
          if (wr && last_rd) state_nxt = ST_TURN;
          else               state_nxt = ST_SETUP;
        end
      end
      ST_TURN:   state_nxt = ST_SETUP;
      ST_SETUP:  if (phase_end) state_nxt = ST_STROBE;
      ST_STROBE: if (phase_end) state_nxt = ST_HOLD;
      ST_HOLD:   if (phase_end) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase

    if (state_nxt != state) begin
      case (state_nxt)
        ST_SETUP:  cnt_nxt = SETUP_LD;
        ST_STROBE: cnt_nxt = STROBE_LD;
        ST_HOLD:   cnt_nxt = HOLD_LD;
        default:   cnt_nxt = '0;
      endcase
    end else if (cnt != '0) begin
      cnt_nxt = cnt - CNT_W'(1);
    end

    // On the accept edge the latched direction is not yet valid.
    op_wr = accept ? wr : wr_q;

    in_cycle_nxt = (state_nxt == ST_SETUP) || (state_nxt == ST_STROBE) ||
                   (state_nxt == ST_HOLD);
    ncs_nxt  = !in_cycle_nxt;
    nwe_nxt  = !((state_nxt == ST_STROBE) && op_wr);
    nrd_nxt  = !((state_nxt == ST_STROBE) && !op_wr);
    oe_nxt   = in_cycle_nxt && op_wr;
    done_nxt = (state == ST_HOLD) && phase_end;
    // Read data is taken on the same edge that releases nrd.
    capture  = (state == ST_STROBE) && phase_end && !wr_q;
  end

  // Request latch, registered bus pins, completion pulse and read-data capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q    <= 1'b0;
      last_rd <= 1'b0;
      addr    <= '0;
      wdata_q <= '0;
      ncs     <= 1'b1;
      nwe     <= 1'b1;
      nrd     <= 1'b1;
      oe_q    <= 1'b0;
      done    <= 1'b0;
      rdata   <= '0;
    end else begin
      if (accept) begin
        wr_q    <= wr;
        last_rd <= !wr;
        addr    <= req_addr;
        wdata_q <= req_wdata;
      end
      ncs  <= ncs_nxt;
      nwe  <= nwe_nxt;
      nrd  <= nrd_nxt;
      oe_q <= oe_nxt;
      done <= done_nxt;
      if (capture) rdata <= din;
    end
  end

endmodule

// File: tb/tb_sram_bus_master.sv
// Scoreboard bench for sram_bus_master: default-timing instance plus a 3/1/2 timing instance.
// Latency: n/a.
// Backpressure: driver holds req until the DUT is idle.
module tb_sram_bus_master;

  localparam int A_TOT = 4;   // SETUP 1 + STROBE 2 + HOLD 1

  logic        clk;
  logic        reset;
  logic        req;
  logic        wr;
  logic [12:0] req_addr;
  logic [7:0]  req_wdata;
  logic        busy;
  logic        done;
  logic [7:0]  rdata;
  logic [12:0] addr;
  tri1  [7:0]  sram_data;
  logic        ncs;
  logic        nwe;
  logic        nrd;

  logic        b_req;
  logic        b_wr;
  logic [12:0] b_req_addr;
  logic [7:0]  b_req_wdata;
  logic        b_busy;
  logic        b_done;
  logic [7:0]  b_rdata;
  logic [12:0] b_addr;
  tri1  [7:0]  b_sram_data;
  logic        b_ncs;
  logic        b_nwe;
  logic        b_nrd;

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;

  sram_bus_master dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .busy(busy), .done(done), .rdata(rdata),
    .addr(addr), .sram_data(sram_data), .ncs(ncs), .nwe(nwe), .nrd(nrd)
  );

  sram_bus_master #(
    .SETUP_CYC(3), .STROBE_CYC(1), .HOLD_CYC(2)
  ) dut_b (
    .clk(clk), .reset(reset), .req(b_req), .wr(b_wr), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .busy(b_busy), .done(b_done), .rdata(b_rdata),
    .addr(b_addr), .sram_data(b_sram_data), .ncs(b_ncs), .nwe(b_nwe), .nrd(b_nrd)
  );

  // SRAM model for the default instance.
  logic [7:0] mem [0:8191];
  logic       mem_init = 1'b0;
  assign sram_data = (!ncs && !nrd) ? mem[addr] : 8'hzz;
  always @(posedge nwe or posedge mem_init) begin
    if (mem_init)            mem[13'h0FF] <= 8'hA5;
    else if (!ncs && reset)  mem[addr] <= sram_data;
  end

  // Fixed-pattern memory for the swept instance.
  assign b_sram_data = (!b_ncs && !b_nrd) ? 8'h96 : 8'hzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  typedef struct {
    logic        is_wr;
    logic [12:0] a;
    logic [7:0]  d;
    int          lat;
    int          gap;
  } exp_t;

  exp_t sb_q[$];

  // Monitor state.
  logic        in_txn = 1'b0;
  int          acc_edge = 0;
  int          ncs_lo = 0, we_lo = 0, rd_lo = 0, hi_run = 0, gap_seen = 0;
  logic        addr_bad = 0, data_bad = 0, float_bad = 0, strobe_bad = 0;
  logic [12:0] a0 = '0;

  always @(negedge clk) begin
    exp_t cur;
    exp_t e;
    if (!reset) begin
      in_txn = 0; hi_run = 0;
      addr_bad = 0; data_bad = 0; float_bad = 0; strobe_bad = 0;
    end else begin
      if (!ncs) begin
        if (!in_txn) begin
          in_txn = 1; gap_seen = hi_run;
          ncs_lo = 0; we_lo = 0; rd_lo = 0; a0 = addr;
        end
        hi_run = 0;
        ncs_lo++;
        if (!nwe) we_lo++;
        if (!nrd) rd_lo++;
        if (addr != a0) addr_bad = 1;
        if (sb_q.size() > 0) begin
          cur = sb_q[0];
          if (cur.is_wr && sram_data != cur.d) data_bad = 1;
          if (!cur.is_wr && nrd && sram_data != 8'hFF) data_bad = 1;
        end
      end else begin
        hi_run++;
        if (!nwe || !nrd) strobe_bad = 1;
        if (sram_data != 8'hFF) float_bad = 1;
      end
      if (done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("latency", cyc - acc_edge + 1, e.lat);
          chk("ncs_low_cycles", ncs_lo, A_TOT);
          chk("strobe_cycles", e.is_wr ? we_lo : rd_lo, 2);
          chk("wrong_strobe", e.is_wr ? rd_lo : we_lo, 0);
          chk("addr", a0, e.a);
          chk("addr_stable", addr_bad, 0);
          chk("data_bus", data_bad, 0);
          chk("bus_float", float_bad, 0);
          chk("strobe_outside_cs", strobe_bad, 0);
          if (!e.is_wr) chk("rdata", rdata, e.d);
          if (e.gap >= 0) chk("ncs_gap", gap_seen, e.gap);
        end
        in_txn = 0;
        addr_bad = 0; data_bad = 0; float_bad = 0; strobe_bad = 0;
      end
      if (req && !busy) acc_edge = cyc + 1;
    end
  end

  // Present a request and hold it until the accepting edge has passed.
  task automatic issue(input logic w, input logic [12:0] a, input logic [7:0] d,
                       input int lat, input int gap, input bit push, input bit hold);
    int t;
    exp_t e;
    if (push) begin
      e.is_wr = w; e.a = a; e.d = d; e.lat = lat; e.gap = gap;
      sb_q.push_back(e);
    end
    req = 1'b1; wr = w; req_addr = a; req_wdata = d;
    t = 0;
    @(negedge clk);
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("accept", busy, 0);
    @(posedge clk);
    #1;
    if (!hold) req = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((sb_q.size() != 0 || busy) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain", sb_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Run one transaction on the swept instance and measure its phases.
  task automatic b_run(input logic w, input logic [12:0] a, input logic [7:0] d,
                       output int su, output int st, output int ho, output int lat,
                       output int bad, output logic [7:0] rd);
    bit seen;
    su = 0; st = 0; ho = 0; lat = -1; bad = 0; rd = '0; seen = 0;
    b_req = 1'b1; b_wr = w; b_req_addr = a; b_req_wdata = d;
    @(posedge clk);
    #1;
    b_req = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (!b_ncs) begin
        if (!(w ? b_nwe : b_nrd)) begin
          st++; seen = 1;
        end else if (!seen) su++;
        else ho++;
        if (w ? (b_sram_data != d) : (b_nrd && b_sram_data != 8'hFF)) bad++;
        if (w ? !b_nrd : !b_nwe) bad++;
      end else if (!b_nwe || !b_nrd) bad++;
      if (b_done) begin
        lat = k; rd = b_rdata;
        break;
      end
    end
  endtask

  initial begin
    int su, st, ho, lat, bad, t;
    logic [7:0] rd;
    logic saw_done;

    reset = 1'b0; req = 1'b0; wr = 1'b0; req_addr = '0; req_wdata = '0;
    b_req = 1'b0; b_wr = 1'b0; b_req_addr = '0; b_req_wdata = '0;
    #1 mem_init = 1'b1;
    #1 mem_init = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_ncs", ncs, 1);
    chk("rst_nwe", nwe, 1);
    chk("rst_nrd", nrd, 1);
    chk("rst_addr", addr, 0);
    chk("rst_bus_z", sram_data, 8'hFF);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rdata", rdata, 0);

    reset = 1'b1;
    @(posedge clk);
    #1;

    // Single write then single read.
    issue(1'b1, 13'h1A5, 8'h3C, 5, -1, 1, 0);
    wait_idle();
    chk("mem_1A5", mem[13'h1A5], 8'h3C);
    issue(1'b0, 13'h0FF, 8'hA5, 5, -1, 1, 0);
    wait_idle();

    // Back-to-back with req held: first write follows a read, so it turns around.
    issue(1'b1, 13'h010, 8'h11, 6, -1, 1, 1);
    issue(1'b1, 13'h011, 8'h22, 5,  1, 1, 1);
    issue(1'b0, 13'h010, 8'h11, 5,  1, 1, 1);
    issue(1'b1, 13'h012, 8'h33, 6,  2, 1, 0);
    wait_idle();
    issue(1'b0, 13'h011, 8'h22, 5, -1, 1, 0);
    issue(1'b0, 13'h012, 8'h33, 5, -1, 1, 0);
    wait_idle();

    // Reset pulled in the middle of a write strobe.
    issue(1'b1, 13'h020, 8'h44, 0, -1, 0, 0);
    t = 0;
    while (nwe && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("reached_strobe", nwe, 0);
    #2 reset = 1'b0;
    #1;
    chk("abort_ncs", ncs, 1);
    chk("abort_nwe", nwe, 1);
    chk("abort_bus_z", sram_data, 8'hFF);
    chk("abort_busy", busy, 0);
    saw_done = 1'b0;
    repeat (5) begin
      @(negedge clk);
      saw_done = saw_done | done;
    end
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      saw_done = saw_done | done;
    end
    chk("abort_no_done", saw_done, 0);
    @(posedge clk);
    #1;
    issue(1'b1, 13'h021, 8'h55, 5, -1, 1, 0);
    issue(1'b0, 13'h021, 8'h55, 5, -1, 1, 0);
    wait_idle();

    // Timing sweep instance: SETUP 3, STROBE 1, HOLD 2.
    b_run(1'b1, 13'h055, 8'h5A, su, st, ho, lat, bad, rd);
    chk("b_wr_setup", su, 3);
    chk("b_wr_strobe", st, 1);
    chk("b_wr_hold", ho, 2);
    chk("b_wr_latency", lat, 7);
    chk("b_wr_bus", bad, 0);
    @(posedge clk);
    #1;
    b_run(1'b0, 13'h055, 8'h00, su, st, ho, lat, bad, rd);
    chk("b_rd_setup", su, 3);
    chk("b_rd_strobe", st, 1);
    chk("b_rd_hold", ho, 2);
    chk("b_rd_latency", lat, 7);
    chk("b_rd_bus", bad, 0);
    chk("b_rdata", rd, 8'h96);

    chk("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_tot);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_bus_master.md
# sram_bus_master

- Synchronous initiator for the 13-bit-address / 8-bit-data asynchronous SRAM-style bus (`ncs`, `nwe`, `nrd`).
- Converts single-cycle requests from FPGA-internal logic into timed bus cycles with programmable setup, strobe and hold.
- Sits at the bus pins when the FPGA must drive the external static-memory bus (BIST, bridging, board test) instead of responding to it.

## Interface
Parameters:
- ADDR_W, 13, address width
- DATA_W, 8, data width
- SETUP_CYC, 1, cycles with `ncs` low before strobe (min 1)
- STROBE_CYC, 2, cycles with `nwe`/`nrd` low (min 1)
- HOLD_CYC, 1, cycles with `ncs` low after strobe (min 1)

Ports:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  1  request; sampled only while `busy`=0
- wr  in  1  1=write, 0=read; sampled with `req`
- req_addr  in  ADDR_W  address; sampled with `req`
- req_wdata  in  DATA_W  write data; sampled with `req`
- busy  out  1  high while a transaction (incl. turnaround) is in progress
- done  out  1  one-cycle completion pulse
- rdata  out  DATA_W  captured read data; valid from `done`, held until next read completes
- addr  out  ADDR_W  bus address
- sram_data  inout  DATA_W  bus data; high-Z unless writing
- ncs  out  1  chip select, active-low
- nwe  out  1  write strobe, active-low
- nrd  out  1  read strobe, active-low

## Operation
- Reset values: `ncs`/`nwe`/`nrd`=1, `addr`=0, `sram_data`=Z, `busy`=0, `done`=0, `rdata`=0. Applied asynchronously on `reset` low, including mid-transaction; an aborted transaction never produces `done`.
- States: IDLE, TURN, SETUP, STROBE, HOLD.
- IDLE: on `req`=1, latch `wr`/`req_addr`/`req_wdata`.
  - Go to TURN if the request is a write and the previous transaction was a read.
  - Otherwise go to SETUP.
- TURN: 1 cycle; bus idle, data high-Z; then SETUP.
- SETUP: `ncs`=0, `addr` driven. On a write, `sram_data` is driven with the latched data. Lasts SETUP_CYC cycles, then STROBE.
- STROBE: `nwe`=0 (write) or `nrd`=0 (read) for STROBE_CYC cycles. On a read, `rdata` is loaded from `sram_data` at the final STROBE edge, i.e. the same edge that deasserts `nrd`.
- HOLD: strobe high, `ncs`=0, `addr` held, write data still driven. Lasts HOLD_CYC cycles, then IDLE with `done`=1.
- `busy` = (state != IDLE). `done` is high in the first IDLE cycle only.
- One shared phase counter, width clog2(max(SETUP_CYC,STROBE_CYC,HOLD_CYC)+1). It is reloaded on every state change and never wraps.
- All bus outputs come directly from registers, so there are no glitches on `ncs`/`nwe`/`nrd`.

## Timing
- Request accepted at edge E0.
- Write, defaults:
  - `ncs` low and data driven after E0.
  - `nwe` low after E1, high after E3.
  - `ncs` high, data Z, `done`=1 after E4.
  - Total 4 cycles of `ncs` low.
- Read, defaults: same timing with `nrd`; `rdata` updates at E3.
- Latency accept→`done` = SETUP_CYC+STROBE_CYC+HOLD_CYC+1 edges, plus 1 when TURN is inserted.
- Back-to-back: `req` held high during the `done` cycle is accepted at that edge. `ncs` is then high for exactly 1 cycle between transactions (2 cycles for read→write).
- `addr` and write data are stable from `ncs` falling until `ncs` rising. The strobe is never low while `ncs` is high.
- `sram_data` is never driven in the cycle after a read's HOLD.

## Structure
- Package `sram_bus_pkg`:
  - state enum
  - default ADDR_W/DATA_W
  - default SETUP/STROBE/HOLD constants
- Sub-module `sram_data_io`: tri-state pad wrapper (out, oe, in) for `sram_data`, so the FSM has no inout logic.
- Everything else is one FSM plus the phase counter.

## Test plan
- Reset check: assert `reset` low → all strobes 1, `addr`=0, `sram_data`=Z, `busy`=0, `rdata`=0.
- Write: `wr`=1, `addr` 0x1A5, data 0x3C → `ncs` low 4 cycles; `nwe` low cycles 2–3; data 0x3C stable throughout; `done` at cycle 5; SRAM model holds 0x3C.
- Read: model holds 0xA5 at 0x0FF → `nrd` low 2 cycles; `rdata`=0xA5 with `done`; `sram_data` never driven by the DUT.
- Back-to-back and turnaround: three requests write, write, read with `req` held → single-cycle `ncs` gaps. Then read→write → 2-cycle gap, with `sram_data` Z in the gap.
- Reset mid-strobe: pull `reset` low during a write STROBE → `nwe`/`ncs` high immediately, data Z, no `done`. The next request after release completes normally.
- Parameter sweep: SETUP=3, STROBE=1, HOLD=2 → phase lengths exact; latency 7 cycles.
